// File: rtl/div_pkg.sv
// Purpose : shared state encodings and special-case constants for the sequential divider.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
//
// Contents: FSM state codes (S_IDLE..S_DONE) and wide constants that the divider
// slices down to its operand width for the divide-by-zero and overflow results.
package div_pkg;

   // FSM state codes
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PREP  = 3'd1;
   localparam logic [2:0] S_ITER  = 3'd2;
   localparam logic [2:0] S_FIXUP = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Widest operand the constants below cover; the divider slices [L-1:0].
   localparam int DIV_MAX_W = 64;

   // Quotient returned on divide-by-zero (all ones at any width).
   localparam logic [DIV_MAX_W-1:0] DIV_ALL_ONES = '1;

   // Seed for the signed minimum (1 << (L-1)) at operand width L.
   localparam logic [DIV_MAX_W-1:0] DIV_ONE = 64'd1;

endpackage

// File: rtl/div_step.sv
// Purpose : one restoring-division step (trial subtract, restore on borrow).
// Latency : combinational, zero cycles.
// Backpressure : none; pure function of its inputs.
//
// Ports:
//   rem_in  [L:0]   partial remainder with the next dividend bit already shifted in
//   divisor [L-1:0] divisor magnitude
//   rem_out [L:0]   next partial remainder
//   q_bit           quotient bit (1 when the subtraction did not borrow)
module div_step #(
   parameter int L = 16
) (
   input  logic [L:0]   rem_in,
   input  logic [L-1:0] divisor,
   output logic [L:0]   rem_out,
   output logic         q_bit
);

   logic         borrow;
   logic [L:0]   diff;

   // One extra bit on the left captures the borrow out of bit L.
   assign {borrow, diff} = {1'b0, rem_in} - {2'b00, divisor};

   assign q_bit   = ~borrow;
   assign rem_out = borrow ? rem_in : diff;

endmodule

// File: rtl/div_sequencer.sv
// Purpose : multi-cycle signed/unsigned integer divider with RISC-V zero/overflow rules.
// Latency : RespValid rises on the (L+3)th edge counting the accept edge (3 with early-out).
// Backpressure : result is held in DONE until RespReady; ReqReady is high only in IDLE.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ReqValid/ReqReady          request handshake; ReqSigned, A, B sampled on acceptance
//   RespValid/RespReady        response handshake; Quotient, Remainder, DivByZero held
//   Busy                       FSM is not idle
// Optional feature macro: DIV_EARLY_OUT_EN (divide-by-zero and overflow skip the
// iteration phase; results are identical, only latency changes).
module div_sequencer
   import div_pkg::*;
#(
   parameter int L  = 16,
   parameter int CW = $clog2(L+1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ReqValid,
   output logic         ReqReady,
   input  logic         ReqSigned,
   input  logic [L-1:0] A,
   input  logic [L-1:0] B,
   output logic         RespValid,
   input  logic         RespReady,
   output logic [L-1:0] Quotient,
   output logic [L-1:0] Remainder,
   output logic         DivByZero,
   output logic         Busy
);

   localparam logic [L-1:0] Q_ALL_ONES = DIV_ALL_ONES[L-1:0];
   localparam logic [L-1:0] S_MIN      = DIV_ONE[L-1:0] << (L-1);

   logic [2:0]    state;
   logic [L-1:0]  a_q, b_q;       // original operands, kept for the special cases
   logic          signed_q;
   logic [L-1:0]  dvd;            // dividend magnitude, shifted out MSB first
   logic [L-1:0]  dvs;            // divisor magnitude
   logic [L-1:0]  quo;            // quotient magnitude, shifted in LSB first
   logic [L:0]    pr;             // partial remainder
   logic [CW-1:0] cnt;
   logic          neg_q, neg_r, zero_f, ovf_f;
   logic          resp_vld, dbz;
   logic [L-1:0]  q_out, r_out;

   logic          sa, sb, prep_zero, prep_ovf;
   logic [L:0]    step_in, pr_next;
   logic          q_bit;
   logic [L-1:0]  q_fix, r_fix;
   logic          unused_pr_msb;

   assign sa        = signed_q & a_q[L-1];
   assign sb        = signed_q & b_q[L-1];
   assign prep_zero = (b_q == '0);
   assign prep_ovf  = signed_q && (a_q == S_MIN) && (b_q == Q_ALL_ONES);

   // The stored remainder is always below the divisor, so its MSB is zero and
   // only the low L bits feed the next shift.
   assign step_in       = {pr[L-1:0], dvd[L-1]};
   assign unused_pr_msb = pr[L];

   div_step #(.L(L)) u_step (
      .rem_in  (step_in),
      .divisor (dvs),
      .rem_out (pr_next),
      .q_bit   (q_bit)
   );

   assign q_fix = neg_q ? ('0 - quo)       : quo;
   assign r_fix = neg_r ? ('0 - pr[L-1:0]) : pr[L-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         signed_q <= 1'b0;
         dvd      <= '0;
         dvs      <= '0;
         quo      <= '0;
         pr       <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         zero_f   <= 1'b0;
         ovf_f    <= 1'b0;
         resp_vld <= 1'b0;
         dbz      <= 1'b0;
         q_out    <= '0;
         r_out    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ReqValid) begin
                  a_q      <= A;
                  b_q      <= B;
                  signed_q <= ReqSigned;
                  state    <= S_PREP;
               end
            end
            S_PREP: begin
               dvd    <= sa ? ('0 - a_q) : a_q;
               dvs    <= sb ? ('0 - b_q) : b_q;
               neg_q  <= sa ^ sb;
               neg_r  <= sa;
               zero_f <= prep_zero;
               ovf_f  <= prep_ovf;
               pr     <= '0;
               quo    <= '0;
               cnt    <= CW'(L);
`ifdef DIV_EARLY_OUT_EN
               state  <= (prep_zero || prep_ovf) ? S_FIXUP : S_ITER;
`else
               state  <= S_ITER;
`endif
            end
            S_ITER: begin
               pr  <= pr_next;
               dvd <= {dvd[L-2:0], 1'b0};
               quo <= {quo[L-2:0], q_bit};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= S_FIXUP;
            end
            S_FIXUP: begin
               if (zero_f) begin
                  q_out <= Q_ALL_ONES;
                  r_out <= a_q;
                  dbz   <= 1'b1;
               end else if (ovf_f) begin
                  q_out <= a_q;
                  r_out <= '0;
                  dbz   <= 1'b0;
               end else begin
                  q_out <= q_fix;
                  r_out <= r_fix;
                  dbz   <= 1'b0;
               end
               resp_vld <= 1'b1;
               state    <= S_DONE;
            end
            S_DONE: begin
               if (RespReady) begin
                  resp_vld <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Gated by rst_n so nothing is offered while reset is held.
   assign ReqReady  = rst_n && (state == S_IDLE);
   assign Busy      = (state != S_IDLE);
   assign RespValid = resp_vld;
   assign Quotient  = q_out;
   assign Remainder = r_out;
   assign DivByZero = dbz;

endmodule

// File: tb/tb_div_sequencer.sv
// Purpose : self-checking bench for div_sequencer (vector table, random model, corner sequences).
// Latency : expects RespValid on the 19th edge counting the accept edge (3 for special cases with DIV_EARLY_OUT_EN).
// Backpressure : exercises RespReady held low and reset during iteration.
module tb_div_sequencer;

   localparam int L = 16;
   localparam int LAT_NORM = L + 3;
`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_SPEC = 3;
`else
   localparam int LAT_SPEC = L + 3;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ReqValid = 1'b0;
   logic         ReqSigned = 1'b0;
   logic [L-1:0] A = '0;
   logic [L-1:0] B = '0;
   logic         RespReady = 1'b0;
   logic         ReqReady, RespValid, DivByZero, Busy;
   logic [L-1:0] Quotient, Remainder;

   div_sequencer #(.L(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ReqValid  (ReqValid),
      .ReqReady  (ReqReady),
      .ReqSigned (ReqSigned),
      .A         (A),
      .B         (B),
      .RespValid (RespValid),
      .RespReady (RespReady),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivByZero (DivByZero),
      .Busy      (Busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         sg;
      logic [L-1:0] a;
      logic [L-1:0] b;
      logic [L-1:0] q;
      logic [L-1:0] r;
      logic         dbz;
      logic         special;
   } vec_t;

   typedef struct {
      logic [L-1:0] q;
      logic [L-1:0] r;
      logic         dbz;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Independent reference: language division plus the RISC-V special cases.
   function automatic exp_t model(input logic sg, input logic [L-1:0] a, input logic [L-1:0] b);
      exp_t e;
      e.lat = LAT_NORM;
      e.dbz = 1'b0;
      if (b == 0) begin
         e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1; e.lat = LAT_SPEC;
      end else if (sg && a == 16'h8000 && b == 16'hFFFF) begin
         e.q = 16'h8000; e.r = 16'h0000; e.lat = LAT_SPEC;
      end else if (sg) begin
         e.q = $signed(a) / $signed(b);
         e.r = $signed(a) % $signed(b);
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   task automatic send(input logic sg, input logic [L-1:0] a, input logic [L-1:0] b, input exp_t e);
      int n = 0;
      while (!ReqReady && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("req_ready_before_send", {31'd0, ReqReady}, 32'd1);
      ReqSigned = sg; A = a; B = b; ReqValid = 1'b1;
      @(posedge clk);
      sb_q.push_back(e);
      #1 ReqValid = 1'b0;
   endtask

   // Waits for RespValid counting edges from the accept edge (which is edge 1).
   task automatic collect(input string tag);
      int   n = 1;
      exp_t e;
      while (!RespValid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_resp_seen"}, {31'd0, RespValid}, 32'd1);
      if (sb_q.size() == 0) begin
         chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_latency"},   n,                  e.lat);
         chk({tag, "_quotient"},  {16'd0, Quotient},  {16'd0, e.q});
         chk({tag, "_remainder"}, {16'd0, Remainder}, {16'd0, e.r});
         chk({tag, "_divbyzero"}, {31'd0, DivByZero}, {31'd0, e.dbz});
         chk({tag, "_reqready_done"}, {31'd0, ReqReady}, 32'd0);
      end
   endtask

   task automatic take(input string tag);
      RespReady = 1'b1;
      @(posedge clk); #1;
      RespReady = 1'b0;
      chk({tag, "_respvalid_cleared"}, {31'd0, RespValid}, 32'd0);
      chk({tag, "_reqready_after_take"}, {31'd0, ReqReady}, 32'd1);
   endtask

   vec_t tbl[9];

   initial begin
      exp_t e;
      tbl[0] = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0};
      tbl[1] = '{1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0, 1'b0};
      tbl[3] = '{1'b1, 16'h1234, 16'd0,    16'hFFFF, 16'h1234, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 16'h1234, 16'd0,    16'hFFFF, 16'h1234, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 1'b1};
      tbl[6] = '{1'b0, 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0, 1'b0};
      tbl[8] = '{1'b1, 16'hFFF9, 16'd0,    16'hFFFF, 16'hFFF9, 1'b1, 1'b1};

      // Reset state while rst_n is held low.
      #12;
      chk("rst_reqready",  {31'd0, ReqReady},   32'd0);
      chk("rst_respvalid", {31'd0, RespValid},  32'd0);
      chk("rst_quotient",  {16'd0, Quotient},   32'd0);
      chk("rst_remainder", {16'd0, Remainder},  32'd0);
      chk("rst_divbyzero", {31'd0, DivByZero},  32'd0);
      chk("rst_busy",      {31'd0, Busy},       32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Table vectors.
      for (int i = 0; i < 9; i++) begin
         e.q   = tbl[i].q;
         e.r   = tbl[i].r;
         e.dbz = tbl[i].dbz;
         e.lat = tbl[i].special ? LAT_SPEC : LAT_NORM;
         send(tbl[i].sg, tbl[i].a, tbl[i].b, e);
         collect($sformatf("vec%0d", i));
         take($sformatf("vec%0d", i));
      end

      // Random vectors against the reference model.
      for (int i = 0; i < 8; i++) begin
         logic         sg;
         logic [L-1:0] a, b;
         sg = 1'($urandom_range(0, 1));
         a  = 16'($urandom);
         b  = (i == 3) ? 16'd0 : 16'($urandom_range(0, 300));
         send(sg, a, b, model(sg, a, b));
         collect($sformatf("rnd%0d", i));
         take($sformatf("rnd%0d", i));
      end

      // Backpressure: result held, no new request accepted.
      e.q = 16'd100; e.r = 16'd0; e.dbz = 1'b0; e.lat = LAT_NORM;
      send(1'b0, 16'd1000, 16'd10, e);
      collect("bp");
      ReqValid = 1'b1; A = 16'd5; B = 16'd1; ReqSigned = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_hold_q%0d", i),   {16'd0, Quotient},  32'd100);
         chk($sformatf("bp_hold_r%0d", i),   {16'd0, Remainder}, 32'd0);
         chk($sformatf("bp_hold_vld%0d", i), {31'd0, RespValid}, 32'd1);
         chk($sformatf("bp_hold_rdy%0d", i), {31'd0, ReqReady},  32'd0);
      end
      ReqValid = 1'b0;
      take("bp");
      repeat (5) @(posedge clk);
      #1;
      chk("bp_no_hidden_accept_busy", {31'd0, Busy},      32'd0);
      chk("bp_no_hidden_accept_vld",  {31'd0, RespValid}, 32'd0);

      // Reset during ITER cycle 5 aborts the request.
      e.q = 16'd3; e.r = 16'd0; e.dbz = 1'b0; e.lat = LAT_NORM;
      send(1'b0, 16'd9, 16'd3, e);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_busy_before", {31'd0, Busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      chk("abort_respvalid", {31'd0, RespValid}, 32'd0);
      chk("abort_quotient",  {16'd0, Quotient},  32'd0);
      chk("abort_remainder", {16'd0, Remainder}, 32'd0);
      chk("abort_divbyzero", {31'd0, DivByZero}, 32'd0);
      chk("abort_busy",      {31'd0, Busy},      32'd0);
      chk("abort_reqready",  {31'd0, ReqReady},  32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_reqready_release", {31'd0, ReqReady},  32'd1);
      chk("abort_no_response",      {31'd0, RespValid}, 32'd0);
      send(1'b0, 16'd9, 16'd3, e);
      collect("post_abort");
      take("post_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
